// File: rtl/hamming_enc_stream.sv
// Streaming systematic Hamming encoder with optional SECDED bit.
// Registered output stage plus skid register; s_ready and m_valid come from flops.
module hamming_enc_stream #(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  parameter int CNT_W  = 16,
  localparam int R = (DATA_W + 4 <= 8)  ? 3 :
                     (DATA_W + 5 <= 16) ? 4 :
                     (DATA_W + 6 <= 32) ? 5 :
                     (DATA_W + 7 <= 64) ? 6 : 7,
  localparam int CODE_W = DATA_W + R + SECDED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CODE_W-1:0] m_code,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state;
  state_t state_n;

  logic [CODE_W-1:0] skid;
  logic [CODE_W-1:0] enc;
  logic              acc;
  logic              emit;
  logic              load_enc;
  logic              load_skid;
  logic              load_from_skid;

  // Data bits fill non-power-of-two positions in ascending order from 3.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [R-1:0]      par;
    logic [R-1:0]      pf;
    logic [CODE_W-1:0] c;
    int                k;
    par = '0;
    pf  = '0;
    k   = 0;
    for (int pos = 3; pos < (1 << R); pos++) begin
      if (k < DATA_W && (pos & (pos - 1)) != 0) begin
        for (int j = 0; j < R; j++) begin
          if (pos[j]) par[j] = par[j] ^ d[DATA_W-1-k];
        end
        k++;
      end
    end
    for (int j = 0; j < R; j++) pf[R-1-j] = par[j];
    c = '0;
    c[CODE_W-1 -: DATA_W] = d;
    c[SECDED +: R] = pf;
    if (SECDED != 0) c[0] = ^{d, par};
    return c;
  endfunction

  assign enc  = encode(s_data);
  assign acc  = s_valid & s_ready;
  assign emit = m_valid & m_ready;

  always_comb begin
    state_n        = state;
    load_enc       = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_n  = ONE;
          load_enc = 1'b1;
        end
      end
      ONE: begin
        if (acc && emit) begin
          load_enc = 1'b1;
        end else if (emit) begin
          state_n = EMPTY;
        end else if (acc) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end
      end
      TWO: begin
        if (emit) begin
          state_n        = ONE;
          load_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_code   <= '0;
      skid     <= '0;
      word_cnt <= '0;
    end else begin
      state   <= state_n;
      s_ready <= (state_n != TWO);
      m_valid <= (state_n != EMPTY);
      if (load_enc) m_code <= enc;
      else if (load_from_skid) m_code <= skid;
      if (load_skid) skid <= enc;
      if (emit) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Bench for hamming_enc_stream: four parameterisations share one stimulus bus.
// Each scenario checks one instance against a position-vector Hamming model.
module tb_hamming_enc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        m_ready;
  logic [15:0] s_data;

  logic [3:0]  rdy;
  logic [3:0]  vld;
  logic [6:0]  c0;
  logic [7:0]  c1;
  logic [12:0] c2;
  logic [15:0] c3;
  logic [3:0]  n0;
  logic [15:0] n1;
  logic [15:0] n2;
  logic [15:0] n3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hamming_enc_stream #(.DATA_W(4), .SECDED(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[0]),
    .s_data(s_data[3:0]), .m_valid(vld[0]), .m_ready(m_ready),
    .m_code(c0), .word_cnt(n0));
  hamming_enc_stream #(.DATA_W(4), .SECDED(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[1]),
    .s_data(s_data[3:0]), .m_valid(vld[1]), .m_ready(m_ready),
    .m_code(c1), .word_cnt(n1));
  hamming_enc_stream #(.DATA_W(8), .SECDED(1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[2]),
    .s_data(s_data[7:0]), .m_valid(vld[2]), .m_ready(m_ready),
    .m_code(c2), .word_cnt(n2));
  hamming_enc_stream #(.DATA_W(11), .SECDED(1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[3]),
    .s_data(s_data[10:0]), .m_valid(vld[3]), .m_ready(m_ready),
    .m_code(c3), .word_cnt(n3));

  task automatic peek(input int sel, output logic v, output logic r,
                      output logic [63:0] code, output logic [63:0] cnt);
    case (sel)
      0: begin v = vld[0]; r = rdy[0]; code = 64'(c0); cnt = 64'(n0); end
      1: begin v = vld[1]; r = rdy[1]; code = 64'(c1); cnt = 64'(n1); end
      2: begin v = vld[2]; r = rdy[2]; code = 64'(c2); cnt = 64'(n2); end
      default: begin v = vld[3]; r = rdy[3]; code = 64'(c3); cnt = 64'(n3); end
    endcase
  endtask

  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // Lay data out on the full 1-based position vector, then derive parities.
  function automatic logic [63:0] ref_code(input int dw, input int sec,
                                           input logic [63:0] din);
    int          r;
    int          k;
    bit          full[128];
    bit          p;
    bit          ov;
    logic [63:0] d;
    logic [63:0] c;
    r = calc_r(dw);
    d = din & ((64'd1 << dw) - 1);
    foreach (full[i]) full[i] = 1'b0;
    k = 0;
    for (int pos = 1; k < dw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        full[pos] = d[dw-1-k];
        k++;
      end
    end
    c  = d;
    ov = ^d;
    for (int j = 0; j < r; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < 128; pos++)
        if (((pos >> j) & 1) == 1) p ^= full[pos];
      c  = (c << 1) | 64'(p);
      ov ^= p;
    end
    if (sec != 0) c = (c << 1) | 64'(ov);
    return c;
  endfunction

  // Classic decoder: XOR of positions holding a 1, plus overall parity flag.
  function automatic int syndrome(input int dw, input int sec,
                                  input logic [63:0] cin);
    int          r;
    int          syn;
    int          k;
    logic [63:0] c;
    logic [63:0] d;
    r   = calc_r(dw);
    syn = 0;
    c   = cin;
    if (sec != 0) begin
      if (^(c & ((64'd1 << (dw + r + 1)) - 1))) syn |= (1 << 16);
      c = c >> 1;
    end
    for (int j = 0; j < r; j++)
      if (c[r-1-j]) syn ^= (1 << j);
    d = c >> r;
    k = 0;
    for (int pos = 1; k < dw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[dw-1-k]) syn ^= pos;
        k++;
      end
    end
    return syn;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic        v;
    logic        r;
    logic [63:0] code;
    logic [63:0] cnt;
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    #1;
    for (int sel = 0; sel < 4; sel++) begin
      peek(sel, v, r, code, cnt);
      n_tests++;
      if (v !== 1'b0 || r !== 1'b1 || code !== 64'd0 || cnt !== 64'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%b r=%b code=%h cnt=%0d, want v=0 r=1 code=0 cnt=0",
                 sel, v, r, code, cnt);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed(input int sel, input int n,
                               input logic [63:0] w[3],
                               input logic [63:0] e[3]);
    logic        v;
    logic        r;
    logic [63:0] code;
    logic [63:0] cnt;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        peek(sel, v, r, code, cnt);
        n_tests++;
        if (v !== 1'b1 || code !== e[i-1]) begin
          n_fail++;
          $display("FAIL directed[%0d] word %0d: got v=%b code=%h, want v=1 code=%h",
                   sel, i - 1, v, code, e[i-1]);
        end
      end
      if (i < n) begin
        s_valid = 1'b1;
        s_data  = w[i][15:0];
      end else begin
        s_valid = 1'b0;
      end
    end
    @(negedge clk);
    peek(sel, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b0 || cnt !== 64'(n)) begin
      n_fail++;
      $display("FAIL directed_cnt[%0d]: got v=%b cnt=%0d, want v=0 cnt=%0d",
               sel, v, cnt, n);
    end
  endtask

  task automatic test_backpressure();
    logic        v;
    logic        r;
    logic        drop;
    logic [63:0] code;
    logic [63:0] cnt;
    logic [63:0] got[$];
    do_reset();
    m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'd1;
    @(negedge clk);
    peek(0, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b1 || r !== 1'b1 || code !== ref_code(4, 0, 1)) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b r=%b code=%h, want v=1 r=1 code=%h",
               v, r, code, ref_code(4, 0, 1));
    end
    s_data = 16'd2;
    @(negedge clk);
    s_data = 16'd3;
    for (int i = 0; i < 4; i++) begin
      peek(0, v, r, code, cnt);
      n_tests++;
      if (v !== 1'b1 || r !== 1'b0 || code !== ref_code(4, 0, 1)) begin
        n_fail++;
        $display("FAIL bp_hold %0d: got v=%b r=%b code=%h, want v=1 r=0 code=%h",
                 i, v, r, code, ref_code(4, 0, 1));
      end
      @(negedge clk);
      s_data = 16'($urandom);
    end
    s_data  = 16'd3;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      #1;
      peek(0, v, r, code, cnt);
      if (v) got.push_back(code);
      drop = s_valid && r;
      @(negedge clk);
      if (drop) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d codewords, want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[i] !== ref_code(4, 0, 64'(i + 1))) begin
          n_fail++;
          $display("FAIL bp_order %0d: got %h, want %h",
                   i, got[i], ref_code(4, 0, 64'(i + 1)));
        end
      end
    end
    @(negedge clk);
    peek(0, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b0 || cnt !== 64'd3) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b cnt=%0d, want v=0 cnt=3", v, cnt);
    end
  endtask

  task automatic test_exhaustive(input int sel, input int dw, input int sec,
                                 input int cntw);
    logic        v;
    logic        r;
    logic [63:0] code;
    logic [63:0] cnt;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int          total;
    int          sent;
    int          recv;
    int          syn;
    total = 1 << dw;
    sent  = 0;
    recv  = 0;
    do_reset();
    for (int cyc = 0; cyc < 12000 && recv < total; cyc++) begin
      @(negedge clk);
      peek(sel, v, r, code, cnt);
      m_ready = ($urandom_range(0, 9) < 7);
      if (r && sent < total && $urandom_range(0, 9) < 8) begin
        s_valid = 1'b1;
        s_data  = 16'(sent);
      end else if (r) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 16'($urandom);
      end
      #1;
      peek(sel, v, r, code, cnt);
      if (v && m_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        n_tests++;
        if (code !== e) begin
          n_fail++;
          $display("FAIL exh[%0d] word %0d: got %h, want %h", sel, recv, code, e);
        end
        syn = syndrome(dw, sec, code);
        n_tests++;
        if (syn != 0) begin
          n_fail++;
          $display("FAIL exh_syn[%0d] word %0d: got syndrome %h, want 0",
                   sel, recv, syn);
        end
        recv++;
      end
      if (s_valid && r) begin
        exp_q.push_back(ref_code(dw, sec, 64'(sent)));
        sent++;
      end
    end
    s_valid = 1'b0;
    n_tests++;
    if (recv != total) begin
      n_fail++;
      $display("FAIL exh_done[%0d]: got %0d words, want %0d", sel, recv, total);
    end
    @(negedge clk);
    peek(sel, v, r, code, cnt);
    n_tests++;
    if (cnt !== 64'(total % (1 << cntw))) begin
      n_fail++;
      $display("FAIL exh_cnt[%0d]: got %0d, want %0d", sel, cnt, total % (1 << cntw));
    end
  endtask

  task automatic test_wrap_reset();
    logic        v;
    logic        r;
    logic [63:0] code;
    logic [63:0] cnt;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    peek(0, v, r, code, cnt);
    n_tests++;
    if (cnt !== 64'd1) begin
      n_fail++;
      $display("FAIL wrap_cnt: got %0d, want 1", cnt);
    end
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'd5;
    @(negedge clk);
    s_data = 16'd6;
    @(negedge clk);
    peek(0, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b1 || r !== 1'b0) begin
      n_fail++;
      $display("FAIL two_state: got v=%b r=%b, want v=1 r=0", v, r);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    peek(0, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b0 || r !== 1'b1 || cnt !== 64'd0 || code !== 64'd0) begin
      n_fail++;
      $display("FAIL async_rst: got v=%b r=%b cnt=%0d code=%h, want v=0 r=1 cnt=0 code=0",
               v, r, cnt, code);
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      peek(0, v, r, code, cnt);
      n_tests++;
      if (v !== 1'b0 || cnt !== 64'd0) begin
        n_fail++;
        $display("FAIL post_rst %0d: got v=%b cnt=%0d, want v=0 cnt=0", i, v, cnt);
      end
    end
    s_valid = 1'b1;
    s_data  = 16'd9;
    @(negedge clk);
    s_valid = 1'b0;
    peek(0, v, r, code, cnt);
    n_tests++;
    if (v !== 1'b1 || code !== ref_code(4, 0, 9)) begin
      n_fail++;
      $display("FAIL post_rst_word: got v=%b code=%h, want v=1 code=%h",
               v, code, ref_code(4, 0, 9));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] w[3];
    logic [63:0] e[3];
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    test_reset();
    w = '{64'hB, 64'h1, 64'h8};
    e = '{64'h5A, 64'h0F, 64'h46};
    test_directed(0, 3, w, e);
    e = '{64'hB4, 64'h1E, 64'h8D};
    test_directed(1, 3, w, e);
    w = '{64'hFF, 64'h00, 64'h00};
    e = '{64'h1FF8, 64'h0000, 64'h0000};
    test_directed(2, 2, w, e);
    test_backpressure();
    test_exhaustive(0, 4, 0, 4);
    test_exhaustive(1, 4, 1, 16);
    test_exhaustive(3, 11, 1, 16);
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
